camera_pixel_reconstruct: RTL and testbench

CAMERA_PIXEL_RECONSTRUCT -- requirements
Module: camera_pixel_reconstruct

---
 rtl/camera_pixel_reconstruct.sv | 209 ++++++++++++++++++++
 tb/tb_camera_pixel_reconstruct.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_pixel_reconstruct.sv
// Rebuilds RGB565 pixels from a raw byte-wide camera bus oversampled in the system
// clock domain, with line/pixel count checking reported once per frame.
module camera_pixel_reconstruct #(
    parameter int unsigned H_ACTIVE = 320,
    parameter int unsigned V_ACTIVE = 240
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        cam_pclk_in,
    input  logic                        cam_hsync_in,
    input  logic                        cam_vsync_in,
    input  logic [7:0]                  cam_data_in,
    output logic                        pixel_valid_out,
    output logic [15:0]                 pixel_data_out,
    output logic [$clog2(H_ACTIVE)-1:0] hcount_out,
    output logic [$clog2(V_ACTIVE)-1:0] vcount_out,
    output logic                        frame_done_out,
    output logic                        frame_err_out
);

    localparam int unsigned SW  = 11;
    localparam int unsigned HW  = $clog2(H_ACTIVE + 1);
    localparam int unsigned VW  = $clog2(V_ACTIVE + 1);
    localparam int unsigned HOW = $clog2(H_ACTIVE);
    localparam int unsigned VOW = $clog2(V_ACTIVE);
    localparam logic [HW-1:0] H_FULL = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_FULL = VW'(V_ACTIVE);

    typedef enum logic [1:0] {
        WAIT_FRAME,
        ACTIVE,
        FRAME_END
    } state_t;

    // Synchronizer bundle layout: {pclk, vsync, hsync, data}
    logic [SW-1:0] sync1_q, sync2_q;
    logic          pclk3_q;
    logic          pclk_rise_c;

    logic          smp_stb_q, smp_hs_q, smp_vs_q, hs_last_q, vs_last_q;
    logic [7:0]    smp_data_q;
    logic          hs_fall_c, vs_fall_c, vs_rise_c, line_end_c;

    state_t         state_q, state_d;
    logic           phase_q, phase_d;
    logic [7:0]     hi_q, hi_d;
    logic [HW-1:0]  hcnt_q, hcnt_d;
    logic [VW-1:0]  lcnt_q, lcnt_d;
    logic           err_q, err_d;
    logic           valid_q, valid_d;
    logic [15:0]    pix_q, pix_d;
    logic [HOW-1:0] hout_q, hout_d;
    logic [VOW-1:0] vout_q, vout_d;
    logic           done_q, done_d;
    logic           ferr_q, ferr_d;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sync1_q <= '0;
            sync2_q <= '0;
            pclk3_q <= 1'b0;
        end else begin
            sync1_q <= {cam_pclk_in, cam_vsync_in, cam_hsync_in, cam_data_in};
            sync2_q <= sync1_q;
            pclk3_q <= sync2_q[10];
        end
    end

    assign pclk_rise_c = sync2_q[10] & ~pclk3_q;

    // Capture the camera bus once per pclk rising edge, keeping the prior sync levels
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            smp_stb_q  <= 1'b0;
            smp_hs_q   <= 1'b0;
            smp_vs_q   <= 1'b0;
            hs_last_q  <= 1'b0;
            vs_last_q  <= 1'b0;
            smp_data_q <= '0;
        end else begin
            smp_stb_q <= pclk_rise_c;
            if (pclk_rise_c) begin
                smp_vs_q   <= sync2_q[9];
                smp_hs_q   <= sync2_q[8];
                smp_data_q <= sync2_q[7:0];
                vs_last_q  <= smp_vs_q;
                hs_last_q  <= smp_hs_q;
            end
        end
    end

    assign hs_fall_c  = hs_last_q & ~smp_hs_q;
    assign vs_fall_c  = vs_last_q & ~smp_vs_q;
    assign vs_rise_c  = smp_vs_q & ~vs_last_q;
    // A vsync rise with hsync still high closes the open line first
    assign line_end_c = hs_fall_c | (vs_rise_c & smp_hs_q);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= WAIT_FRAME;
            phase_q <= 1'b0;
            hi_q    <= '0;
            hcnt_q  <= '0;
            lcnt_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            pix_q   <= '0;
            hout_q  <= '0;
            vout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            hi_q    <= hi_d;
            hcnt_q  <= hcnt_d;
            lcnt_q  <= lcnt_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            pix_q   <= pix_d;
            hout_q  <= hout_d;
            vout_q  <= vout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        hi_d    = hi_q;
        hcnt_d  = hcnt_q;
        lcnt_d  = lcnt_q;
        err_d   = err_q;
        valid_d = 1'b0;
        pix_d   = pix_q;
        hout_d  = hout_q;
        vout_d  = vout_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            WAIT_FRAME: begin
                if (smp_stb_q && vs_fall_c) begin
                    state_d = ACTIVE;
                    phase_d = 1'b0;
                    hcnt_d  = '0;
                    lcnt_d  = '0;
                    err_d   = 1'b0;
                end
            end
            ACTIVE: begin
                if (smp_stb_q) begin
                    if (line_end_c) begin
                        phase_d = 1'b0;
                        hcnt_d  = '0;
                        if (phase_q || (hcnt_q != H_FULL) || (lcnt_q == V_FULL)) begin
                            err_d = 1'b1;
                        end
                        if (lcnt_q != V_FULL) begin
                            lcnt_d = lcnt_q + VW'(1);
                        end
                    end else if (smp_hs_q && !vs_rise_c) begin
                        if (lcnt_q == V_FULL) begin
                            err_d = 1'b1;
                        end else if (!phase_q) begin
                            hi_d    = smp_data_q;
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if (hcnt_q != H_FULL) begin
                                valid_d = 1'b1;
                                pix_d   = {hi_q, smp_data_q};
                                hout_d  = HOW'(hcnt_q);
                                vout_d  = VOW'(lcnt_q);
                                hcnt_d  = hcnt_q + HW'(1);
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    end
                    if (vs_rise_c) begin
                        if (line_end_c) begin
                            state_d = FRAME_END;
                        end else begin
                            state_d = WAIT_FRAME;
                            done_d  = 1'b1;
                            ferr_d  = err_q | (lcnt_q != V_FULL);
                        end
                    end
                end
            end
            FRAME_END: begin
                state_d = WAIT_FRAME;
                done_d  = 1'b1;
                ferr_d  = err_q | (lcnt_q != V_FULL);
            end
            default: state_d = WAIT_FRAME;
        endcase
    end

    assign pixel_valid_out = valid_q;
    assign pixel_data_out  = pix_q;
    assign hcount_out      = hout_q;
    assign vcount_out      = vout_q;
    assign frame_done_out  = done_q;
    assign frame_err_out   = ferr_q;

endmodule

// File: tb/tb_camera_pixel_reconstruct.sv
// Directed plus randomized frames against a line/byte-level reference model of the
// pixel reconstructor, with H_ACTIVE=4 and V_ACTIVE=2.
module tb_camera_pixel_reconstruct;

    localparam int H    = 4;
    localparam int V    = 2;
    localparam int MAXL = 4;
    typedef int len_t [MAXL];

    logic                 clk;
    logic                 rst_n;
    logic                 pclk, hs, vs;
    logic [7:0]           data;
    logic                 pixel_valid;
    logic [15:0]          pixel_data;
    logic [$clog2(H)-1:0] hcount;
    logic [$clog2(V)-1:0] vcount;
    logic                 frame_done, frame_err;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    logic [31:0] obs_pix[$];
    int unsigned obs_cyc[$];
    logic        done_q[$];
    logic [7:0]  bytes_q[$];
    int unsigned rise_q[$];
    logic [31:0] exp_pix[$];
    logic        exp_err;

    camera_pixel_reconstruct #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk_in          (clk),
        .rst_in          (rst_n),
        .cam_pclk_in     (pclk),
        .cam_hsync_in    (hs),
        .cam_vsync_in    (vs),
        .cam_data_in     (data),
        .pixel_valid_out (pixel_valid),
        .pixel_data_out  (pixel_data),
        .hcount_out      (hcount),
        .vcount_out      (vcount),
        .frame_done_out  (frame_done),
        .frame_err_out   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe away from the active edge
    always @(negedge clk) begin
        if (pixel_valid) begin
            obs_pix.push_back({pixel_data, 8'(hcount), 8'(vcount)});
            obs_cyc.push_back(cyc);
        end
        if (frame_done) done_q.push_back(frame_err);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        obs_pix.delete();
        obs_cyc.delete();
        done_q.delete();
        bytes_q.delete();
        rise_q.delete();
    endtask

    // One camera byte: pclk low 4 clocks with bus set up, then high 4 clocks
    task automatic pclk_cycle(input logic h, input logic v, input logic [7:0] d);
        pclk = 1'b0;
        hs   = h;
        vs   = v;
        data = d;
        repeat (4) @(negedge clk);
        pclk = 1'b1;
        if (h && !v) begin
            bytes_q.push_back(d);
            rise_q.push_back(cyc + 1);
        end
        repeat (4) @(negedge clk);
    endtask

    // Reference: pair bytes per line, keep only in-range pixels, flag any count anomaly
    task automatic model(input int nlines, input len_t len);
        int pos;
        int npix;
        exp_pix.delete();
        exp_err = (nlines != V);
        pos = 0;
        for (int l = 0; l < nlines; l++) begin
            npix = len[l] / 2;
            if ((len[l] % 2) != 0 || npix != H || l >= V) exp_err = 1'b1;
            if (l < V) begin
                for (int k = 0; k < npix && k < H; k++) begin
                    exp_pix.push_back({bytes_q[pos + 2*k], bytes_q[pos + 2*k + 1], 8'(k), 8'(l)});
                end
            end
            pos += len[l];
        end
    endtask

    task automatic run_frame(input int nlines, input len_t len, input bit pattern, input bit end_hs);
        logic [7:0] d;
        clear_obs();
        repeat (2) pclk_cycle(1'b0, 1'b1, 8'h00);
        repeat (2) pclk_cycle(1'b0, 1'b0, 8'h00);
        for (int l = 0; l < nlines; l++) begin
            for (int b = 0; b < len[l]; b++) begin
                d = pattern ? 8'(32'h12 + 32'h22 * 32'(bytes_q.size())) : 8'($urandom);
                pclk_cycle(1'b1, 1'b0, d);
            end
            if (!(end_hs && l == nlines - 1)) repeat (2) pclk_cycle(1'b0, 1'b0, 8'h00);
        end
        if (end_hs) pclk_cycle(1'b1, 1'b1, 8'hFF);
        repeat (2) pclk_cycle(1'b0, 1'b1, 8'h00);
        model(nlines, len);
    endtask

    task automatic check_frame(input string tag);
        check({tag, ":strobes"}, 32'(obs_pix.size()), 32'(exp_pix.size()));
        for (int i = 0; i < exp_pix.size(); i++) begin
            if (i < obs_pix.size()) check($sformatf("%s:pix%0d", tag, i), obs_pix[i], exp_pix[i]);
        end
        check({tag, ":done_pulses"}, 32'(done_q.size()), 32'd1);
        if (done_q.size() > 0) check({tag, ":frame_err"}, 32'(done_q[0]), 32'(exp_err));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":valid"}, 32'(pixel_valid), 32'd0);
        check({tag, ":done"},  32'(frame_done),  32'd0);
        check({tag, ":err"},   32'(frame_err),   32'd0);
        check({tag, ":data"},  32'(pixel_data),  32'd0);
        check({tag, ":hcount"}, 32'(hcount),     32'd0);
        check({tag, ":vcount"}, 32'(vcount),     32'd0);
    endtask

    initial begin
        len_t L;
        int   n;
        bit   e;

        rst_n = 1'b0;
        pclk  = 1'b0;
        hs    = 1'b0;
        vs    = 1'b0;
        data  = 8'h00;
        repeat (3) @(negedge clk);
        pclk = 1'b1; hs = 1'b1; vs = 1'b1; data = 8'hC3;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        pclk = 1'b0; hs = 1'b0; vs = 1'b0; data = 8'h00;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // hsync activity before any vsync fall produces nothing
        clear_obs();
        repeat (8) pclk_cycle(1'b1, 1'b0, 8'($urandom));
        repeat (2) pclk_cycle(1'b0, 1'b0, 8'h00);
        check("no_vs_fall:strobes", 32'(obs_pix.size()), 32'd0);
        check("no_vs_fall:done",    32'(done_q.size()),  32'd0);

        L = '{8, 8, 0, 0};
        run_frame(2, L, 1'b1, 1'b0);
        check_frame("nominal");
        check("nominal:strobes8", 32'(obs_pix.size()), 32'd8);
        check("nominal:first_pix", (obs_pix.size() > 0) ? obs_pix[0] : 32'hFFFF_FFFF, 32'h1234_0000);
        check("nominal:latency", (obs_cyc.size() > 0) ? 32'(obs_cyc[0] - rise_q[1]) : 32'hFFFF_FFFF, 32'd3);
        check("nominal:hold", {pixel_data, 8'(hcount), 8'(vcount)}, exp_pix[exp_pix.size() - 1]);

        L = '{7, 8, 0, 0};
        run_frame(2, L, 1'b0, 1'b0);
        check_frame("odd_byte");
        check("odd_byte:strobes7", 32'(obs_pix.size()), 32'd7);

        L = '{12, 8, 0, 0};
        run_frame(2, L, 1'b0, 1'b0);
        check_frame("long_line");

        L = '{8, 0, 0, 0};
        run_frame(1, L, 1'b0, 1'b0);
        check_frame("short_frame");
        check("short_frame:err1", (done_q.size() > 0) ? 32'(done_q[0]) : 32'hFFFF_FFFF, 32'd1);
        L = '{8, 8, 0, 0};
        run_frame(2, L, 1'b0, 1'b0);
        check_frame("after_short");

        run_frame(2, L, 1'b0, 1'b1);
        check_frame("vs_with_hs");

        L = '{8, 8, 8, 0};
        run_frame(3, L, 1'b0, 1'b0);
        check_frame("extra_line");

        // Reset asserted mid-line, then hsync keeps toggling without a vsync fall
        clear_obs();
        repeat (2) pclk_cycle(1'b0, 1'b1, 8'h00);
        repeat (2) pclk_cycle(1'b0, 1'b0, 8'h00);
        pclk_cycle(1'b1, 1'b0, 8'h5A);
        pclk_cycle(1'b1, 1'b0, 8'hA5);
        pclk_cycle(1'b1, 1'b0, 8'h3C);
        check("mid_rst:pre_pixel", (obs_pix.size() > 0) ? obs_pix[0] : 32'hFFFF_FFFF, 32'h5AA5_0000);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
        repeat (5) pclk_cycle(1'b1, 1'b0, 8'($urandom));
        repeat (2) pclk_cycle(1'b0, 1'b0, 8'h00);
        repeat (4) pclk_cycle(1'b1, 1'b0, 8'($urandom));
        pclk_cycle(1'b0, 1'b0, 8'h00);
        check("post_rst:strobes", 32'(obs_pix.size()), 32'd0);
        check("post_rst:done",    32'(done_q.size()),  32'd0);
        L = '{8, 8, 0, 0};
        run_frame(2, L, 1'b0, 1'b0);
        check_frame("post_rst_frame");
        check("post_rst_frame:hv0", (obs_pix.size() > 0) ? 32'(obs_pix[0][15:0]) : 32'hFFFF_FFFF, 32'd0);

        for (int f = 0; f < 6; f++) begin
            n = int'($urandom_range(1, 3));
            for (int i = 0; i < MAXL; i++) L[i] = int'($urandom_range(6, 10));
            e = 1'($urandom_range(0, 1));
            run_frame(n, L, 1'b0, e);
            check_frame($sformatf("rnd%0d", f));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
